// File: rtl/bp_be_int_scoreboard_if.sv
// Issue/dispatch/writeback bundle between the decoder, the hazard scoreboard and the regfile.
// Signal names keep the scoreboard-side view (_i into the scoreboard, _o out of it).
interface bp_be_int_scoreboard_if #(
    parameter int reg_addr_width_p  = 5,
    parameter int stall_cnt_width_p = 16
);
    logic                           instr_v_i;
    logic                           instr_ready_o;
    logic                           rs1_v_i;
    logic [reg_addr_width_p-1:0]    rs1_addr_i;
    logic                           rs2_v_i;
    logic [reg_addr_width_p-1:0]    rs2_addr_i;
    logic                           rd_v_i;
    logic [reg_addr_width_p-1:0]    rd_addr_i;
    logic                           dispatch_ready_i;
    logic                           dispatch_v_o;
    logic                           dispatch_rd_v_o;
    logic [reg_addr_width_p-1:0]    dispatch_rd_addr_o;
    logic                           rs1_r_v_o;
    logic [reg_addr_width_p-1:0]    rs1_addr_o;
    logic                           rs2_r_v_o;
    logic [reg_addr_width_p-1:0]    rs2_addr_o;
    logic                           wb_v_i;
    logic [reg_addr_width_p-1:0]    wb_addr_i;
    logic                           flush_i;
    logic [reg_addr_width_p:0]      busy_count_o;
    logic [stall_cnt_width_p-1:0]   stall_cnt_o;

    modport master (
        output instr_v_i, rs1_v_i, rs1_addr_i, rs2_v_i, rs2_addr_i, rd_v_i, rd_addr_i,
               dispatch_ready_i, wb_v_i, wb_addr_i, flush_i,
        input  instr_ready_o, dispatch_v_o, dispatch_rd_v_o, dispatch_rd_addr_o,
               rs1_r_v_o, rs1_addr_o, rs2_r_v_o, rs2_addr_o, busy_count_o, stall_cnt_o
    );

    modport slave (
        input  instr_v_i, rs1_v_i, rs1_addr_i, rs2_v_i, rs2_addr_i, rd_v_i, rd_addr_i,
               dispatch_ready_i, wb_v_i, wb_addr_i, flush_i,
        output instr_ready_o, dispatch_v_o, dispatch_rd_v_o, dispatch_rd_addr_o,
               rs1_r_v_o, rs1_addr_o, rs2_r_v_o, rs2_addr_o, busy_count_o, stall_cnt_o
    );
endinterface

// File: rtl/bp_be_int_scoreboard.sv
// Integer issue scoreboard: one-entry skid buffer gated by per-register busy bits (RAW/WAW),
// driving the regfile read ports on release.
module bp_be_int_scoreboard #(
    parameter int reg_addr_width_p  = 5,
    parameter int stall_cnt_width_p = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_be_int_scoreboard_if.slave sb_if
);
    localparam int RA = reg_addr_width_p;
    localparam int NR = 1 << RA;
    localparam int CW = RA + 1;
    localparam int SW = stall_cnt_width_p;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rs1_v;
    logic [RA-1:0]   r_rs1_addr;
    logic            r_rs2_v;
    logic [RA-1:0]   r_rs2_addr;
    logic            r_rd_v;
    logic [RA-1:0]   r_rd_addr;

    logic [NR-1:0]   r_busy;
    logic [NR-1:0]   w_busy_nxt;
    logic [NR-1:0]   w_busy_eff;
    logic [NR-1:0]   w_set;
    logic [NR-1:0]   w_clr;
    logic [CW-1:0]   r_busy_cnt;
    logic [CW-1:0]   w_busy_cnt_nxt;
    logic [SW-1:0]   r_stall_cnt;

    logic            w_full;
    logic            w_raw;
    logic            w_waw;
    logic            w_hazard;
    logic            w_dispatch;
    logic            w_ready;
    logic            w_accept;
    logic            w_inc;
    logic            w_dec;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == {SW{1'b1}}) ? v : v + SW'(1);
    endfunction

    // Hazard evaluation: a writeback landing this cycle already frees its register,
    // the regfile forwards the write data to the read issued alongside it.
    assign w_full     = (r_state == S_FULL);
    assign w_busy_eff = r_busy & ~w_clr;
    assign w_raw      = (r_rs1_v & w_busy_eff[r_rs1_addr]) | (r_rs2_v & w_busy_eff[r_rs2_addr]);
    assign w_waw      = r_rd_v & w_busy_eff[r_rd_addr];
    assign w_hazard   = w_full & (w_raw | w_waw);
    assign w_dispatch = w_full & ~w_raw & ~w_waw & sb_if.dispatch_ready_i & ~sb_if.flush_i;
    assign w_ready    = (r_state == S_EMPTY) | w_dispatch;
    assign w_accept   = sb_if.instr_v_i & w_ready & ~sb_if.flush_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (sb_if.instr_v_i && !sb_if.flush_i) w_state_nxt = S_FULL;
            S_FULL: begin
                if (sb_if.flush_i)                          w_state_nxt = S_EMPTY;
                else if (w_dispatch && !sb_if.instr_v_i)    w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Busy bookkeeping; x0 is filtered on both set and clear so it can never become busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_dispatch && r_rd_v && (r_rd_addr != '0)) w_set[r_rd_addr] = 1'b1;
        if (sb_if.wb_v_i && (sb_if.wb_addr_i != '0))   w_clr[sb_if.wb_addr_i] = 1'b1;
    end

    assign w_busy_nxt     = sb_if.flush_i ? '0 : ((r_busy & ~w_clr) | w_set);
    assign w_inc          = |(w_set & ~r_busy);
    assign w_dec          = |(w_clr & r_busy & ~w_set);
    assign w_busy_cnt_nxt = sb_if.flush_i ? '0 : (r_busy_cnt + CW'(w_inc) - CW'(w_dec));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_EMPTY;
            r_busy      <= '0;
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
            if (w_hazard && !sb_if.flush_i) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    // Skid entry payload; only meaningful while FULL, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_rs1_v    <= sb_if.rs1_v_i;
            r_rs1_addr <= sb_if.rs1_addr_i;
            r_rs2_v    <= sb_if.rs2_v_i;
            r_rs2_addr <= sb_if.rs2_addr_i;
            r_rd_v     <= sb_if.rd_v_i;
            r_rd_addr  <= sb_if.rd_addr_i;
        end
    end

    assign sb_if.instr_ready_o      = w_ready;
    assign sb_if.dispatch_v_o       = w_dispatch;
    assign sb_if.dispatch_rd_v_o    = r_rd_v;
    assign sb_if.dispatch_rd_addr_o = r_rd_addr;
    assign sb_if.rs1_r_v_o          = w_dispatch & r_rs1_v;
    assign sb_if.rs1_addr_o         = r_rs1_addr;
    assign sb_if.rs2_r_v_o          = w_dispatch & r_rs2_v;
    assign sb_if.rs2_addr_o         = r_rs2_addr;
    assign sb_if.busy_count_o       = r_busy_cnt;
    assign sb_if.stall_cnt_o        = r_stall_cnt;

endmodule

// File: tb/tb_bp_be_int_scoreboard.sv
// Directed bench for bp_be_int_scoreboard: issued instructions queue their expected release,
// a negedge monitor pops and compares each dispatch; cycle checks cover hazards, flush and counters.
module tb_bp_be_int_scoreboard;
    localparam int RA = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_be_int_scoreboard_if #(.reg_addr_width_p(RA), .stall_cnt_width_p(16)) sb ();
    bp_be_int_scoreboard_if #(.reg_addr_width_p(RA), .stall_cnt_width_p(2))  sb2 ();

    assign sb2.instr_v_i        = sb.instr_v_i;
    assign sb2.rs1_v_i          = sb.rs1_v_i;
    assign sb2.rs1_addr_i       = sb.rs1_addr_i;
    assign sb2.rs2_v_i          = sb.rs2_v_i;
    assign sb2.rs2_addr_i       = sb.rs2_addr_i;
    assign sb2.rd_v_i           = sb.rd_v_i;
    assign sb2.rd_addr_i        = sb.rd_addr_i;
    assign sb2.dispatch_ready_i = sb.dispatch_ready_i;
    assign sb2.wb_v_i           = sb.wb_v_i;
    assign sb2.wb_addr_i        = sb.wb_addr_i;
    assign sb2.flush_i          = sb.flush_i;

    bp_be_int_scoreboard #(.reg_addr_width_p(RA), .stall_cnt_width_p(16)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .sb_if   (sb)
    );

    bp_be_int_scoreboard #(.reg_addr_width_p(RA), .stall_cnt_width_p(2)) dut_sw2 (
        .clk_i   (clk),
        .reset_i (rst),
        .sb_if   (sb2)
    );

    typedef struct packed {
        logic          rd_v;
        logic [RA-1:0] rd;
        logic          rs1_v;
        logic [RA-1:0] rs1;
        logic          rs2_v;
        logic [RA-1:0] rs2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sb.dispatch_v_o === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dispatch_unexpected: got dispatch with rd=%0d expected none", sb.dispatch_rd_addr_o);
            end else begin
                mon_e   = q.pop_front();
                mon_got = {sb.dispatch_rd_v_o, sb.dispatch_rd_addr_o, sb.rs1_r_v_o, sb.rs1_addr_o,
                           sb.rs2_r_v_o, sb.rs2_addr_o};
                chk("dispatch_payload", 32'(mon_got), 32'(mon_e));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic ins(input logic rs1v, input logic [RA-1:0] rs1, input logic rs2v, input logic [RA-1:0] rs2,
                       input logic rdv, input logic [RA-1:0] rd, input bit push);
        sb.instr_v_i  = 1'b1;
        sb.rs1_v_i    = rs1v;
        sb.rs1_addr_i = rs1;
        sb.rs2_v_i    = rs2v;
        sb.rs2_addr_i = rs2;
        sb.rd_v_i     = rdv;
        sb.rd_addr_i  = rd;
        if (push) q.push_back('{rdv, rd, rs1v, rs1, rs2v, rs2});
    endtask

    task automatic noins();
        sb.instr_v_i  = 1'b0;
        sb.rs1_v_i    = 1'b0;
        sb.rs1_addr_i = '0;
        sb.rs2_v_i    = 1'b0;
        sb.rs2_addr_i = '0;
        sb.rd_v_i     = 1'b0;
        sb.rd_addr_i  = '0;
    endtask

    task automatic wb(input logic v, input logic [RA-1:0] a);
        sb.wb_v_i    = v;
        sb.wb_addr_i = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        noins();
        wb(1'b0, '0);
        sb.flush_i          = 1'b0;
        sb.dispatch_ready_i = 1'b1;
        nxt();
        mid();
        chk("rst_dispatch_v", sb.dispatch_v_o, 0);
        chk("rst_busy_count", sb.busy_count_o, 0);
        chk("rst_stall_cnt", sb.stall_cnt_o, 0);
        chk("rst_rs1_r_v", sb.rs1_r_v_o, 0);
        chk("rst_rs2_r_v", sb.rs2_r_v_o, 0);
        nxt();
        rst = 1'b0;
        mid();
        chk("rst_ready", sb.instr_ready_o, 1);
        nxt();

        // RAW on x5, released by same-cycle writeback
        ins(0, 0, 0, 0, 1, 5, 1);
        mid(); chk("t1_ready_empty", sb.instr_ready_o, 1);
        nxt();
        ins(1, 5, 0, 0, 0, 0, 1);
        mid(); chk("t1_disp_rd5", sb.dispatch_v_o, 1); chk("t1_ready_b2b", sb.instr_ready_o, 1);
        nxt();
        noins();
        mid(); chk("t1_raw_block", sb.dispatch_v_o, 0); chk("t1_busy_1", sb.busy_count_o, 1);
        chk("t1_ready_full", sb.instr_ready_o, 0); chk("t1_stall_0", sb.stall_cnt_o, 0);
        nxt();
        mid(); chk("t1_stall_1", sb.stall_cnt_o, 1); chk("t1_still_blocked", sb.dispatch_v_o, 0);
        nxt();
        wb(1, 5);
        mid(); chk("t1_wb_release", sb.dispatch_v_o, 1); chk("t1_stall_2", sb.stall_cnt_o, 2);
        nxt();
        wb(0, 0);
        mid(); chk("t1_busy_0", sb.busy_count_o, 0); chk("t1_stall_hold", sb.stall_cnt_o, 2);
        chk("t1_idle", sb.dispatch_v_o, 0);
        nxt();

        // WAW on x7; writeback under backpressure so busy_count goes 1 -> 0 -> 1
        ins(0, 0, 0, 0, 1, 7, 1);
        mid();
        nxt();
        ins(0, 0, 0, 0, 1, 7, 1);
        mid(); chk("t2_disp_first", sb.dispatch_v_o, 1);
        nxt();
        noins();
        mid(); chk("t2_waw_block", sb.dispatch_v_o, 0); chk("t2_busy_1", sb.busy_count_o, 1);
        nxt();
        wb(1, 7);
        sb.dispatch_ready_i = 1'b0;
        mid(); chk("t2_backpressure", sb.dispatch_v_o, 0); chk("t2_stall_3", sb.stall_cnt_o, 3);
        nxt();
        wb(0, 0);
        sb.dispatch_ready_i = 1'b1;
        mid(); chk("t2_busy_0", sb.busy_count_o, 0); chk("t2_disp_second", sb.dispatch_v_o, 1);
        chk("t2_bp_not_counted", sb.stall_cnt_o, 3);
        nxt();
        wb(1, 7);
        mid(); chk("t2_busy_1_again", sb.busy_count_o, 1);
        nxt();
        wb(0, 0);
        mid(); chk("t2_busy_cleared", sb.busy_count_o, 0);
        nxt();

        // x0 destinations/sources never block: one dispatch per cycle
        ins(1, 0, 1, 10, 1, 0, 1);
        mid(); chk("t3_ready", sb.instr_ready_o, 1);
        nxt();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) ins(1, 0, 1, 5'(11 + i), 1, 0, 1);
            else noins();
            mid(); chk("t3_disp_each_cycle", sb.dispatch_v_o, 1); chk("t3_busy_0", sb.busy_count_o, 0);
            nxt();
        end
        mid(); chk("t3_drained", sb.dispatch_v_o, 0);
        nxt();

        // Same-cycle set and clear of x9: set wins
        ins(0, 0, 0, 0, 1, 9, 1);
        mid();
        nxt();
        ins(0, 0, 0, 0, 1, 9, 1);
        mid(); chk("t4_disp_first", sb.dispatch_v_o, 1);
        nxt();
        ins(1, 9, 0, 0, 0, 0, 1);
        wb(1, 9);
        mid(); chk("t4_waw_released", sb.dispatch_v_o, 1); chk("t4_busy_1", sb.busy_count_o, 1);
        nxt();
        noins();
        wb(0, 0);
        mid(); chk("t4_x9_still_busy", sb.dispatch_v_o, 0); chk("t4_busy_net0", sb.busy_count_o, 1);
        nxt();
        wb(1, 9);
        mid(); chk("t4_release", sb.dispatch_v_o, 1); chk("t4_stall_4", sb.stall_cnt_o, 4);
        nxt();
        wb(0, 0);
        mid(); chk("t4_busy_0", sb.busy_count_o, 0);
        nxt();

        // Flush with three busy registers and a blocked entry
        ins(0, 0, 0, 0, 1, 1, 1);
        mid();
        nxt();
        ins(0, 0, 0, 0, 1, 2, 1);
        mid(); chk("t5_disp_x1", sb.dispatch_v_o, 1);
        nxt();
        ins(0, 0, 0, 0, 1, 3, 1);
        mid(); chk("t5_disp_x2", sb.dispatch_v_o, 1);
        nxt();
        ins(1, 1, 0, 0, 0, 0, 0);
        mid(); chk("t5_disp_x3", sb.dispatch_v_o, 1);
        nxt();
        ins(0, 0, 0, 0, 1, 4, 0);
        sb.flush_i = 1'b1;
        mid(); chk("t5_flush_no_disp", sb.dispatch_v_o, 0); chk("t5_busy_3", sb.busy_count_o, 3);
        nxt();
        noins();
        sb.flush_i = 1'b0;
        mid(); chk("t5_busy_cleared", sb.busy_count_o, 0); chk("t5_ready_empty", sb.instr_ready_o, 1);
        chk("t5_no_disp", sb.dispatch_v_o, 0); chk("t5_flush_not_stall", sb.stall_cnt_o, 4);
        nxt();
        mid(); chk("t5_not_accepted", sb.dispatch_v_o, 0);
        nxt();

        // Asynchronous reset while a register is busy
        ins(0, 0, 0, 0, 1, 8, 1);
        mid();
        nxt();
        noins();
        mid(); chk("ar_disp_x8", sb.dispatch_v_o, 1);
        nxt();
        chk("ar_busy_before", sb.busy_count_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy_async", sb.busy_count_o, 0);
        chk("ar_stall_async", sb.stall_cnt_o, 0);
        chk("ar_stall2_async", sb2.stall_cnt_o, 0);
        nxt();
        rst = 1'b0;
        nxt();

        // Narrow counter saturates; backpressure without hazard is not counted
        ins(0, 0, 0, 0, 1, 6, 1);
        mid();
        nxt();
        ins(0, 0, 1, 6, 0, 0, 1);
        mid(); chk("t6_disp_x6", sb.dispatch_v_o, 1);
        nxt();
        noins();
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("t6_blocked", sb.dispatch_v_o, 0);
            chk("t6_stall16", sb.stall_cnt_o, i);
            chk("t6_stall2", sb2.stall_cnt_o, (i < 3) ? i : 3);
            nxt();
        end
        wb(1, 6);
        ins(0, 0, 0, 0, 0, 0, 1);
        mid(); chk("t6_release", sb.dispatch_v_o, 1); chk("t6_stall16_6", sb.stall_cnt_o, 6);
        chk("t6_stall2_sat", sb2.stall_cnt_o, 3);
        nxt();
        wb(0, 0);
        noins();
        sb.dispatch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid(); chk("t6_bp_hold", sb.dispatch_v_o, 0); chk("t6_bp_stall", sb.stall_cnt_o, 6);
            nxt();
        end
        sb.dispatch_ready_i = 1'b1;
        mid(); chk("t6_bp_release", sb.dispatch_v_o, 1); chk("t6_stall2_final", sb2.stall_cnt_o, 3);
        nxt();
        mid(); chk("t6_idle", sb.dispatch_v_o, 0);
        nxt();

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
